// File: rtl/mad_result_buffer.sv
// mad_result_buffer: tags mad ops, aligns tags with fixed-latency results, queues them behind a credit-gated FIFO
module mad_result_buffer #(
  parameter int DEPTH   = 4,
  parameter int ID_W    = 3,
  parameter int MAD_LAT = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         issue_valid_i,
  input  logic [ID_W-1:0]              issue_id_i,
  input  logic [4:0]                   issue_rd_i,
  output logic                         issue_ready_o,
  input  logic                         mad_valid_i,
  input  logic [31:0]                  mad_result_i,
  output logic                         result_valid_o,
  input  logic                         result_ready_i,
  output logic [31:0]                  result_data_o,
  output logic [ID_W-1:0]              result_id_o,
  output logic [4:0]                   result_rd_o,
  output logic                         result_we_o,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy_o,
  output logic                         err_o
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int SW = $clog2(DEPTH+MAD_LAT+1);
  localparam int EW = 32+ID_W+5;
  logic [MAD_LAT-1:0]           v_q, v_d;
  logic [MAD_LAT-1:0][ID_W-1:0] id_q, id_d;
  logic [MAD_LAT-1:0][4:0]      rd_q, rd_d;
  logic [DEPTH-1:0][EW-1:0]     mem_q, mem_d;
  logic [PW-1:0]                wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic                         err_q, err_d;
  logic [SW-1:0]                inflight;
  logic                         issue_ok, tag_v, push, pop;
  always_comb begin
    inflight = '0;
    for (int i = 0; i < MAD_LAT; i++) inflight = inflight + SW'(v_q[i]);
  end
  // credit counts every tagged op still in flight, so mad can never overrun the FIFO
  assign issue_ready_o  = (SW'(cnt_q) + inflight) < SW'(DEPTH);
  assign issue_ok       = issue_valid_i & issue_ready_o;
  assign tag_v          = v_q[MAD_LAT-1];
  assign result_valid_o = cnt_q != '0;
  assign pop            = result_valid_o & result_ready_i;
  assign push           = tag_v & mad_valid_i & ((cnt_q != CW'(DEPTH)) | pop);
  assign v_d            = MAD_LAT'({v_q, issue_ok});
  assign id_d           = (MAD_LAT*ID_W)'({id_q, issue_id_i});
  assign rd_d           = (MAD_LAT*5)'({rd_q, issue_rd_i});
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wp_q] = {mad_result_i, id_q[MAD_LAT-1], rd_q[MAD_LAT-1]};
    wp_d  = push ? ((wp_q == PW'(DEPTH-1)) ? '0 : wp_q + PW'(1)) : wp_q;
    rp_d  = pop ? ((rp_q == PW'(DEPTH-1)) ? '0 : rp_q + PW'(1)) : rp_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    err_d = err_q | (issue_valid_i & ~issue_ready_o) | (tag_v ^ mad_valid_i)
          | (tag_v & mad_valid_i & ~push);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v_q   <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      v_q   <= v_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  always_ff @(posedge clk_i) begin
    id_q  <= id_d;
    rd_q  <= rd_d;
    mem_q <= mem_d;
  end
  assign {result_data_o, result_id_o, result_rd_o} = result_valid_o ? mem_q[rp_q] : '0;
  assign result_we_o = result_valid_o;
  assign occupancy_o = cnt_q;
  assign err_o       = err_q;
endmodule

// File: tb/tb_mad_result_buffer.sv
// tb_mad_result_buffer: directed checks of tagging, credit, ordering, error and reset behaviour
module tb_mad_result_buffer;
  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        issue_valid_i = 1'b0;
  logic [2:0]  issue_id_i = '0;
  logic [4:0]  issue_rd_i = '0;
  logic        issue_ready_o;
  logic        mad_valid_i;
  logic [31:0] mad_result_i;
  logic        result_valid_o;
  logic        result_ready_i = 1'b0;
  logic [31:0] result_data_o;
  logic [2:0]  result_id_o;
  logic [4:0]  result_rd_o;
  logic        result_we_o;
  logic [2:0]  occupancy_o;
  logic        err_o;
  int          vectors = 0;
  int          miscompares = 0;
  int          delivered = 0;
  logic        auto_m = 1'b0, man_v = 1'b0, sb_on = 1'b0;
  logic [31:0] man_d = '0, issue_data = '0;
  logic        p1_v = 1'b0, p2_v = 1'b0;
  logic [31:0] p1_d = '0, p2_d = '0;
  logic [39:0] exp_q[$];
  always #5 clk = ~clk;
  // two-cycle mad model fed by the issue port when auto_m is set
  always @(posedge clk) begin
    p1_v <= issue_valid_i & auto_m;
    p1_d <= issue_data;
    p2_v <= p1_v;
    p2_d <= p1_d;
  end
  assign mad_valid_i  = auto_m ? p2_v : man_v;
  assign mad_result_i = auto_m ? p2_d : man_d;
  mad_result_buffer dut (
    .clk_i(clk), .rst_i(rst_i),
    .issue_valid_i(issue_valid_i), .issue_id_i(issue_id_i), .issue_rd_i(issue_rd_i),
    .issue_ready_o(issue_ready_o),
    .mad_valid_i(mad_valid_i), .mad_result_i(mad_result_i),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .result_data_o(result_data_o), .result_id_o(result_id_o), .result_rd_o(result_rd_o),
    .result_we_o(result_we_o), .occupancy_o(occupancy_o), .err_o(err_o)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    if (sb_on && issue_valid_i) exp_q.push_back({issue_data, issue_id_i, issue_rd_i});
    if (sb_on && result_valid_o && result_ready_i) begin
      if (exp_q.size() == 0) chk("sb_extra", 64'(result_valid_o), 64'd0);
      else begin
        chk("sb_order", 64'({result_data_o, result_id_o, result_rd_o}), 64'(exp_q[0]));
        void'(exp_q.pop_front());
        delivered++;
      end
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    int n_iss, t, d0;
    #1;
    cyc(); cyc();
    rst_i = 1'b0;
    chk("rst_valid", result_valid_o, 0);
    chk("rst_we", result_we_o, 0);
    chk("rst_data", result_data_o, 0);
    chk("rst_id", result_id_o, 0);
    chk("rst_rd", result_rd_o, 0);
    chk("rst_occ", occupancy_o, 0);
    chk("rst_ready", issue_ready_o, 1);
    chk("rst_err", err_o, 0);
    // single op through manually driven mad
    result_ready_i = 1'b1;
    issue_valid_i = 1'b1; issue_id_i = 3'd5; issue_rd_i = 5'd10;
    chk("s1_ready", issue_ready_o, 1);
    cyc();
    issue_valid_i = 1'b0;
    cyc();
    man_v = 1'b1; man_d = 32'h123;
    chk("s1_nopre", result_valid_o, 0);
    cyc();
    man_v = 1'b0;
    chk("s1_valid", result_valid_o, 1);
    chk("s1_we", result_we_o, 1);
    chk("s1_data", result_data_o, 32'h123);
    chk("s1_id", result_id_o, 5);
    chk("s1_rd", result_rd_o, 10);
    chk("s1_occ", occupancy_o, 1);
    cyc();
    chk("s1_empty", result_valid_o, 0);
    chk("s1_data0", result_data_o, 0);
    chk("s1_occ0", occupancy_o, 0);
    chk("s1_err", err_o, 0);
    // fill with consumer stalled, then drain in order
    auto_m = 1'b1; sb_on = 1'b1; result_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      issue_valid_i = 1'b1; issue_id_i = 3'(k); issue_rd_i = 5'(k + 8); issue_data = 32'h1000 + k;
      chk("s2_ready_on", issue_ready_o, 1);
      cyc();
    end
    issue_valid_i = 1'b0;
    chk("s2_ready_off", issue_ready_o, 0);
    cyc(); cyc();
    chk("s2_occ4", occupancy_o, 4);
    chk("s2_ready_full", issue_ready_o, 0);
    cyc();
    chk("s2_hold_id", result_id_o, 0);
    chk("s2_hold_data", result_data_o, 32'h1000);
    chk("s2_hold_occ", occupancy_o, 4);
    result_ready_i = 1'b1;
    chk("s2_pop_nocredit", issue_ready_o, 0);
    cyc(); cyc(); cyc(); cyc();
    chk("s2_drained", result_valid_o, 0);
    chk("s2_ready_back", issue_ready_o, 1);
    chk("s2_count", delivered, 4);
    // full buffer, consumer ready, continuous issue
    result_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      issue_valid_i = 1'b1; issue_id_i = 3'(k + 4); issue_rd_i = 5'(k + 16); issue_data = 32'h2000 + k;
      cyc();
    end
    issue_valid_i = 1'b0;
    cyc(); cyc();
    chk("s3_full", occupancy_o, 4);
    result_ready_i = 1'b1;
    chk("s3_ready_a", issue_ready_o, 0);
    cyc();
    for (int j = 0; j < 8; j++) begin
      issue_valid_i = 1'b1; issue_id_i = 3'(j); issue_rd_i = 5'(j + 3); issue_data = 32'h3000 + j;
      chk("s3_ready", issue_ready_o, 1);
      if (j >= 2) chk("s3_occ", occupancy_o, 1);
      cyc();
    end
    issue_valid_i = 1'b0;
    for (int j = 0; j < 5; j++) cyc();
    chk("s3_empty", occupancy_o, 0);
    chk("s3_count", delivered, 16);
    chk("s3_err", err_o, 0);
    // 12 ops with ready toggling, wrapping the pointers
    n_iss = 0; t = 0; d0 = delivered;
    while ((delivered - d0) < 12 && t < 300) begin
      result_ready_i = (t % 2) == 0;
      if (n_iss < 12 && issue_ready_o) begin
        issue_valid_i = 1'b1; issue_id_i = 3'(n_iss % 8); issue_rd_i = 5'(n_iss + 1);
        issue_data = 32'hABC0_0000 + 32'(n_iss) * 32'h111;
        n_iss++;
      end else issue_valid_i = 1'b0;
      cyc();
      t++;
    end
    issue_valid_i = 1'b0; result_ready_i = 1'b1;
    cyc(); cyc(); cyc();
    chk("s4_count", delivered - d0, 12);
    chk("s4_left", exp_q.size(), 0);
    chk("s4_err", err_o, 0);
    // result with no tag pending
    auto_m = 1'b0; sb_on = 1'b0;
    man_v = 1'b1; man_d = 32'hDEAD;
    cyc();
    man_v = 1'b0;
    chk("s5_err", err_o, 1);
    chk("s5_nopush", occupancy_o, 0);
    chk("s5_novalid", result_valid_o, 0);
    cyc(); cyc();
    chk("s5_sticky", err_o, 1);
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    chk("s5_rst_err", err_o, 0);
    // reset while an op is in flight
    issue_valid_i = 1'b1; issue_id_i = 3'd2; issue_rd_i = 5'd7;
    cyc();
    issue_valid_i = 1'b0; rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    chk("s6_valid", result_valid_o, 0);
    chk("s6_occ", occupancy_o, 0);
    chk("s6_ready", issue_ready_o, 1);
    chk("s6_err0", err_o, 0);
    man_v = 1'b1; man_d = 32'h55;
    cyc();
    man_v = 1'b0;
    chk("s6_err", err_o, 1);
    chk("s6_valid2", result_valid_o, 0);
    chk("s6_occ2", occupancy_o, 0);
    cyc();
    chk("s6_valid3", result_valid_o, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
